// File: rtl/bcd_down_timer.sv
// BCD mm:ss countdown timer with start/stop/load control, en-pulse prescaler and sticky load error.
// Optional feature: define TIMER_AUTO_RELOAD_EN to reload the preset and keep running at 00:00.
module bcd_down_timer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] count,
    output logic        bo,
    output logic        done,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t      state_q;
    logic [15:0] count_q;
    logic [15:0] preset_q;
    logic [7:0]  presc_q;
    logic        bo_q;
    logic        done_q;
    logic        busy_q;
    logic        err_q;

    logic        load_ok;
    logic        tick;
    logic        last;
    logic        secs_zero;
    logic [15:0] dec_d;

    always_comb begin
        load_ok   = (load_val[3:0] <= 4'd9) && (load_val[7:4] <= 4'd5) &&
                    (load_val[11:8] <= 4'd9) && (load_val[15:12] <= 4'd5);
        tick      = (state_q == RUN) && en && (presc_q == 8'(TICK_DIV - 1));
        last      = (count_q == 16'h0001);
        secs_zero = (count_q[7:0] == 8'h00);
    end

    // Ripple borrow from seconds-ones up through minutes-tens.
    always_comb begin
        dec_d = count_q;
        if (count_q[3:0] != 4'd0) begin
            dec_d[3:0] = count_q[3:0] - 4'd1;
        end else begin
            dec_d[3:0] = 4'd9;
            if (count_q[7:4] != 4'd0) begin
                dec_d[7:4] = count_q[7:4] - 4'd1;
            end else begin
                dec_d[7:4] = 4'd5;
                if (count_q[11:8] != 4'd0) begin
                    dec_d[11:8] = count_q[11:8] - 4'd1;
                end else begin
                    dec_d[11:8]  = 4'd9;
                    dec_d[15:12] = count_q[15:12] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            preset_q <= '0;
            presc_q  <= '0;
            bo_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            bo_q   <= 1'b0;
            done_q <= 1'b0;
            // A load of any kind consumes the cycle, so no tick or other command can slip in.
            if (load) begin
                if (load_ok) begin
                    count_q  <= load_val;
                    preset_q <= load_val;
                    presc_q  <= '0;
                    err_q    <= 1'b0;
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (stop && (state_q == RUN || state_q == PAUSE)) begin
                state_q <= PAUSE;
                busy_q  <= 1'b0;
            end else if (start && state_q == IDLE && count_q != '0) begin
                state_q <= RUN;
                busy_q  <= 1'b1;
                presc_q <= '0;
            end else if (start && state_q == PAUSE) begin
                state_q <= RUN;
                busy_q  <= 1'b1;
            end else if (state_q == RUN && en) begin
                if (!tick) begin
                    presc_q <= presc_q + 8'd1;
                end else begin
                    presc_q <= '0;
                    if (last) begin
                        done_q <= 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                        count_q <= preset_q;
`else
                        count_q <= '0;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        count_q <= dec_d;
                        bo_q    <= secs_zero;
                    end
                end
            end
        end
    end

    assign count = count_q;
    assign bo    = bo_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: doc/bcd_down_timer.md
BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1: number of accepted en pulses per decrement (legal 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port en  input  1  one-cycle tick strobe (e.g. 1 Hz enable).
REQ-005 SHALL have port load  input  1  load preset from load_val.
REQ-006 SHALL have port load_val  input  16  BCD preset {min_tens,min_ones,sec_tens,sec_ones}.
REQ-007 SHALL have port start  input  1  start or resume countdown.
REQ-008 SHALL have port stop  input  1  pause countdown.
REQ-009 SHALL have port count  output  16  current BCD mm:ss value, same digit order as load_val.
REQ-010 SHALL have port bo  output  1  one-cycle borrow pulse when seconds wrap 00->59.
REQ-011 SHALL have port done  output  1  one-cycle pulse when count reaches 00:00.
REQ-012 SHALL have port busy  output  1  high while in RUN.
REQ-013 SHALL have port err  output  1  sticky flag for an invalid load.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE, DONE; all outputs SHALL be registered.
REQ-015 Command priority SHALL be load > stop > start when asserted in the same cycle.
REQ-016 Valid load in any state: count<=load_val, stored preset<=load_val, prescaler<=0, err<=0, state->IDLE.
REQ-017 A load is valid only if every ones digit <=9 and both tens digits <=5.
REQ-018 Invalid load: count, preset and state unchanged; err<=1 until the next valid load or reset.
REQ-019 start in IDLE with count!=0000: state->RUN, prescaler<=0.
REQ-020 start in IDLE with count==0000 SHALL be ignored.
REQ-021 stop in RUN: state->PAUSE, prescaler held; start in PAUSE: state->RUN, prescaler resumes.
REQ-022 start in RUN or DONE SHALL be ignored; stop in IDLE or DONE SHALL be ignored.
REQ-023 Prescaler SHALL count en pulses only in RUN; the decrement tick fires on the en pulse where prescaler==TICK_DIV-1, prescaler then returns to 0.
REQ-024 On a tick, count SHALL update at that same clock edge (zero added latency).
REQ-025 Decrement: sec_ones 0->9 borrows sec_tens; sec_tens 0->5 borrows min_ones; min_ones 0->9 borrows min_tens; all other digits hold.
REQ-026 bo SHALL pulse for exactly the cycle following the edge where seconds go 00->59.
REQ-027 Tick producing 0000: done SHALL pulse one cycle and state->DONE; count holds 0000; bo SHALL NOT assert on that tick.
REQ-028 en pulses outside RUN SHALL have no effect on count or prescaler.
REQ-029 busy SHALL equal (state==RUN).

Reset
REQ-030 rst low SHALL immediately force count=0000, preset=0000, prescaler=0, bo=0, done=0, busy=0, err=0, state=IDLE, including mid-countdown.
REQ-031 After rst release, the first command SHALL be honoured on the first rising clk edge.

Configuration
REQ-032 With macro TIMER_AUTO_RELOAD_EN defined: a tick reaching 0000 SHALL pulse done, load count<=preset, reset the prescaler and stay in RUN; DONE is never entered.
REQ-033 Without TIMER_AUTO_RELOAD_EN: behaviour per REQ-027; only a load exits DONE.

Verification
REQ-034 TICK_DIV=1, load 0x0102, start, 62 en pulses -> count 0101 after pulse 1, bo at 0059 transition (pulse 3), done and count 0000 after pulse 62, busy 0.
REQ-035 load 0x0A00 -> err=1, count unchanged; then load 0x0030 -> err=0, count 0030.
REQ-036 Running at 0045: stop, 5 en pulses, start, 1 en -> count stays 0045 while paused, then 0044.
REQ-037 TICK_DIV=3, load 0x0003, start, 9 en pulses -> decrements only on pulses 3, 6, 9; done on pulse 9.
REQ-038 load, start and stop asserted in the same cycle while in RUN -> load wins, state IDLE, busy 0.
REQ-039 rst low during RUN at 0530 -> count 0000, all flags 0 asynchronously; with TIMER_AUTO_RELOAD_EN, preset 0002 -> count 0002 after done, busy stays 1.
